decade_counter_ctrl: RTL

Sequencer for the team's 7490-style decade counter (R0/R9 asynchronous preset inputs, four QA..QD outputs). It accepts commands over a valid/ready handshake to clear, preset-to-9, or advance the counter by N counts. It drives the counter's count strobe and preset lines with fixed, parameterised timing. It reads back QD..QA after every action, checks it against an internal BCD model, and tracks decade wrap-arounds.

---
 rtl/decade_ctrl_pkg.sv | 29 ++
 rtl/decade_ctrl_timer.sv | 39 +++
 rtl/decade_counter_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/decade_ctrl_pkg.sv
// Shared definitions for the 7490 decade counter sequencer: command op codes,
// controller state encoding, BCD limits and the BCD increment helper.
package decade_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_SET9  = 2'b01,
    OP_RUN   = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESET,
    ST_PSETTLE,
    ST_STROBE,
    ST_CSETTLE,
    ST_FIN
  } state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;
  localparam logic [3:0] BCD_NINE = 4'd9;

  function automatic logic [3:0] bcd_inc(input logic [3:0] v);
    return (v == BCD_MAX) ? BCD_ZERO : v + 4'd1;
  endfunction

endpackage

// File: rtl/decade_ctrl_timer.sv
// Loadable down-counter shared by the preset pulse and both settle intervals.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   load        - load load_val this cycle (takes priority over counting)
//   load_val    - value loaded; the interval lasts load_val+1 cycles
//   zero        - counter has reached zero (last cycle of the interval)
module decade_ctrl_timer #(
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          zero
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/decade_counter_ctrl.sv
// Sequencer for a 7490-style decade counter: clears, presets to 9 or advances
// the counter by N counts, reads QD..QA back after each action against a BCD
// model and counts decade wrap-arounds.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   cmd_valid/cmd_ready   - command handshake; cmd_op, cmd_len latched at accept
//   abort                 - end a RUN after the strobe in progress
//   cnt_clk, r0, r9       - counter count strobe and preset lines
//   q                     - counter outputs QD..QA
//   busy, done            - command in progress / one-cycle completion pulse
//   err                   - sticky readback mismatch
//   exp_q, wraps          - model value and 9->0 transition count
//
// state      | meaning
// -----------+---------------------------------------------------
// ST_IDLE    | waiting for a command, cmd_ready high
// ST_PRESET  | r0 or r9 held high for PULSE_W cycles
// ST_PSETTLE | preset released, waiting SETTLE cycles, then check
// ST_STROBE  | cnt_clk high for one cycle
// ST_CSETTLE | cnt_clk low for SETTLE cycles, then check
// ST_FIN     | done pulse, back to idle
module decade_counter_ctrl
  import decade_ctrl_pkg::*;
#(
  parameter int PULSE_W = 3,
  parameter int SETTLE  = 2,
  parameter int NW      = 8,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [NW-1:0] cmd_len,
  input  logic          abort,
  output logic          cnt_clk,
  output logic          r0,
  output logic          r9,
  input  logic [3:0]    q,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [3:0]    exp_q,
  output logic [CW-1:0] wraps
);

  localparam int TMAX = (PULSE_W > SETTLE) ? PULSE_W : SETTLE;
  localparam int TW   = $clog2(TMAX + 1);

  state_e        state_q;
  logic [NW-1:0] len_q;
  logic          abort_q;
  logic          cnt_clk_q, r0_q, r9_q, busy_q, done_q, err_q;
  logic [3:0]    exp_q_q;
  logic [CW-1:0] wraps_q;

  logic          accept;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;

  assign cmd_ready = (state_q == ST_IDLE) && rst_n;
  assign accept    = cmd_valid && cmd_ready;

  // Timer is loaded on the edge that enters each timed state, so zero marks
  // the final cycle of that state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept && (cmd_op == OP_CLEAR || cmd_op == OP_SET9)) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(PULSE_W - 1);
        end
      end
      ST_PRESET: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(SETTLE - 1);
        end
      end
      ST_STROBE: begin
        tmr_load = 1'b1;
        tmr_val  = TW'(SETTLE - 1);
      end
      default: ;
    endcase
  end

  decade_ctrl_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      abort_q   <= 1'b0;
      cnt_clk_q <= 1'b0;
      r0_q      <= 1'b0;
      r9_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      exp_q_q   <= BCD_ZERO;
      wraps_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            busy_q  <= 1'b1;
            abort_q <= 1'b0;
            len_q   <= cmd_len;
            unique case (op_e'(cmd_op))
              OP_CLEAR: begin
                state_q <= ST_PRESET;
                r0_q    <= 1'b1;
                exp_q_q <= BCD_ZERO;
                wraps_q <= '0;
                err_q   <= 1'b0;
              end
              OP_SET9: begin
                state_q <= ST_PRESET;
                r9_q    <= 1'b1;
                exp_q_q <= BCD_NINE;
              end
              OP_RUN: begin
                if (cmd_len != '0) begin
                  state_q   <= ST_STROBE;
                  cnt_clk_q <= 1'b1;
                end else begin
                  state_q <= ST_FIN;
                  done_q  <= 1'b1;
                end
              end
              default: begin
                state_q <= ST_FIN;
                done_q  <= 1'b1;
              end
            endcase
          end
        end
        ST_PRESET: begin
          if (tmr_zero) begin
            state_q <= ST_PSETTLE;
            r0_q    <= 1'b0;
            r9_q    <= 1'b0;
          end
        end
        ST_PSETTLE: begin
          if (tmr_zero) begin
            if (q != exp_q_q) err_q <= 1'b1;
            state_q <= ST_FIN;
            done_q  <= 1'b1;
          end
        end
        ST_STROBE: begin
          // Counter advances on this falling edge of cnt_clk; model follows.
          cnt_clk_q <= 1'b0;
          state_q   <= ST_CSETTLE;
          exp_q_q   <= bcd_inc(exp_q_q);
          if (exp_q_q == BCD_MAX) wraps_q <= wraps_q + CW'(1);
          len_q     <= len_q - NW'(1);
          if (abort) abort_q <= 1'b1;
        end
        ST_CSETTLE: begin
          if (abort) abort_q <= 1'b1;
          if (tmr_zero) begin
            if (q > BCD_MAX || q != exp_q_q) begin
              err_q   <= 1'b1;
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else if (len_q == '0 || abort_q || abort) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_STROBE;
              cnt_clk_q <= 1'b1;
            end
          end
        end
        ST_FIN: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cnt_clk = cnt_clk_q;
  assign r0      = r0_q;
  assign r9      = r9_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign exp_q   = exp_q_q;
  assign wraps   = wraps_q;

endmodule
